// File: rtl/vec_div_if.sv
// Start/busy/done handshake and lane data bus of the iterative vector divider.
interface vec_div_if #(
    parameter int LANES = 4,
    parameter int FXP_N = 16
);
    logic                         start;
    logic                         sgn;
    logic [LANES-1:0][FXP_N-1:0]  in_1;
    logic [LANES-1:0][FXP_N-1:0]  in_2;
    logic                         busy;
    logic                         done;
    logic [LANES-1:0][FXP_N-1:0]  out;
    logic [LANES-1:0]             dbz;
    logic [LANES-1:0]             ovf;

    modport master (output start, sgn, in_1, in_2, input busy, done, out, dbz, ovf);
    modport slave  (input start, sgn, in_1, in_2, output busy, done, out, dbz, ovf);
endinterface

// File: rtl/vec_div_iter.sv
// Iterative element-wise fixed-point vector divider, one restoring quotient bit per cycle.
// Optional macro VEC_DIV_ROUND_EN: one extra guard iteration, round half away from zero.
module vec_div_iter #(
    parameter int LANES = 4,
    parameter int FXP_N = 16,
    parameter int FXP_Q = 8
) (
    input logic      clk,
    input logic      rst,
    vec_div_if.slave bus
);
    localparam int ITERS = FXP_N + FXP_Q;
`ifdef VEC_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int QW = ITERS + GUARD;
    localparam int MW = ITERS + 1;
    localparam int CW = $clog2(QW + 1);

    localparam logic [MW-1:0] POS_LIM = MW'((64'd1 << (FXP_N - 1)) - 64'd1);
    localparam logic [MW-1:0] NEG_LIM = MW'(64'd1 << (FXP_N - 1));
    localparam logic [MW-1:0] U_LIM   = MW'((64'd1 << FXP_N) - 64'd1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]                  state;
    logic [CW-1:0]               cnt;
    logic                        accept;
    logic                        sgn_p0;
    logic [LANES-1:0][QW-1:0]    dq_p0;
    logic [LANES-1:0][FXP_N-1:0] rem_p0;
    logic [LANES-1:0][FXP_N-1:0] dvs_p0;
    logic [LANES-1:0]            an_p0, bn_p0, az_p0, bz_p0;
    logic [LANES-1:0][FXP_N:0]   trial;
    logic [LANES-1:0][QW-1:0]    dq_nxt;
    logic [LANES-1:0][FXP_N-1:0] rem_nxt;
    logic [LANES-1:0][FXP_N-1:0] fin_out;
    logic [LANES-1:0]            fin_ovf;

    function automatic logic [FXP_N-1:0] negate(input logic [FXP_N-1:0] x);
        return ~x + {{(FXP_N-1){1'b0}}, 1'b1};
    endfunction

    // |-2^(N-1)| wraps to 2^(N-1), which is exactly right when read as unsigned.
    function automatic logic [FXP_N-1:0] mag_of(input logic [FXP_N-1:0] x, input logic s);
        return (s && x[FXP_N-1]) ? negate(x) : x;
    endfunction

    function automatic logic [MW-1:0] round_mag(input logic [QW-1:0] q);
`ifdef VEC_DIV_ROUND_EN
        return MW'(q[QW-1:1]) + MW'(q[0]);
`else
        return MW'(q);
`endif
    endfunction

    function automatic logic [FXP_N:0] saturate(input logic [MW-1:0] mag, input logic neg,
                                                input logic s);
        logic [FXP_N-1:0] low;
        low = mag[FXP_N-1:0];
        if (s && !neg && mag > POS_LIM) return {1'b1, 1'b0, {(FXP_N-1){1'b1}}};
        if (s && neg && mag > NEG_LIM)  return {1'b1, 1'b1, {(FXP_N-1){1'b0}}};
        if (!s && mag > U_LIM)          return {1'b1, {FXP_N{1'b1}}};
        return {1'b0, neg ? negate(low) : low};
    endfunction

    function automatic logic [FXP_N-1:0] dbz_value(input logic a_zero, input logic a_neg,
                                                   input logic s);
        if (a_zero) return '0;
        if (a_neg)  return {1'b1, {(FXP_N-1){1'b0}}};
        return s ? {1'b0, {(FXP_N-1){1'b1}}} : {FXP_N{1'b1}};
    endfunction

    assign accept = (state == S_IDLE) && bus.start;

    // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            trial[l] = {rem_p0[l], dq_p0[l][QW-1]};
            if (trial[l] >= {1'b0, dvs_p0[l]}) begin
                rem_nxt[l] = FXP_N'(trial[l] - {1'b0, dvs_p0[l]});
                dq_nxt[l]  = {dq_p0[l][QW-2:0], 1'b1};
            end else begin
                rem_nxt[l] = trial[l][FXP_N-1:0];
                dq_nxt[l]  = {dq_p0[l][QW-2:0], 1'b0};
            end
        end
    end

    // Final stage: divide-by-zero override, else round, restore sign, saturate.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            fin_out[l] = '0;
            fin_ovf[l] = 1'b0;
            if (bz_p0[l]) begin
                fin_out[l] = dbz_value(az_p0[l], an_p0[l], sgn_p0);
            end else begin
                {fin_ovf[l], fin_out[l]} = saturate(round_mag(dq_p0[l]), an_p0[l] ^ bn_p0[l], sgn_p0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.out  <= '0;
            bus.dbz  <= '0;
            bus.ovf  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    bus.busy <= 1'b1;
                    cnt      <= cnt + CW'(1);
                    if (cnt == CW'(QW - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    bus.out  <= fin_out;
                    bus.ovf  <= fin_ovf;
                    bus.dbz  <= bz_p0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture on the accepting edge, then one iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            sgn_p0 <= bus.sgn;
            for (int l = 0; l < LANES; l++) begin
                an_p0[l]  <= bus.sgn & bus.in_1[l][FXP_N-1];
                bn_p0[l]  <= bus.sgn & bus.in_2[l][FXP_N-1];
                az_p0[l]  <= (bus.in_1[l] == '0);
                bz_p0[l]  <= (bus.in_2[l] == '0);
                dvs_p0[l] <= mag_of(bus.in_2[l], bus.sgn);
                rem_p0[l] <= '0;
                dq_p0[l]  <= {mag_of(bus.in_1[l], bus.sgn), {(FXP_Q+GUARD){1'b0}}};
            end
        end else if (state == S_RUN) begin
            dq_p0  <= dq_nxt;
            rem_p0 <= rem_nxt;
        end
    end
endmodule

// File: tb/tb_vec_div_iter.sv
// Bench for vec_div_iter: directed plan vectors, handshake/reset cases and random lanes vs an arithmetic model.
`timescale 1ns/1ps
module tb_vec_div_iter;
    localparam int LANES = 4;
    localparam int N     = 16;
    localparam int Q     = 8;
`ifdef VEC_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int LAT = N + Q + 1 + GUARD;

    typedef logic [LANES-1:0][N-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   extra;
    vec_t ra, rb;
    logic rs;

    vec_div_if #(.LANES(LANES), .FXP_N(N)) bus ();
    vec_div_iter #(.LANES(LANES), .FXP_N(N), .FXP_Q(Q)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the real-valued operands.
    function automatic void model(input logic s, input vec_t a, input vec_t b,
                                  output vec_t o, output logic [LANES-1:0] z,
                                  output logic [LANES-1:0] v);
        longint av, bv, ma, mb, q, res;
        for (int l = 0; l < LANES; l++) begin
            av = s ? longint'($signed(a[l])) : longint'(a[l]);
            bv = s ? longint'($signed(b[l])) : longint'(b[l]);
            z[l] = 1'b0;
            v[l] = 1'b0;
            if (bv == 0) begin
                z[l] = 1'b1;
                if (av == 0)     o[l] = '0;
                else if (av < 0) o[l] = 16'h8000;
                else             o[l] = s ? 16'h7FFF : 16'hFFFF;
            end else begin
                ma = (av < 0) ? -av : av;
                mb = (bv < 0) ? -bv : bv;
`ifdef VEC_DIV_ROUND_EN
                q = (((ma << (Q + 1)) / mb) + 1) / 2;
`else
                q = (ma << Q) / mb;
`endif
                res = ((av < 0) != (bv < 0)) ? -q : q;
                if (s && res > 32767)       begin o[l] = 16'h7FFF; v[l] = 1'b1; end
                else if (s && res < -32768) begin o[l] = 16'h8000; v[l] = 1'b1; end
                else if (!s && res > 65535) begin o[l] = 16'hFFFF; v[l] = 1'b1; end
                else                          o[l] = res[N-1:0];
            end
        end
    endfunction

    task automatic do_op(input string tag, input logic s, input vec_t a, input vec_t b,
                         input int poke_at);
        vec_t             eo;
        logic [LANES-1:0] ez, ev;
        int               lat, bcnt;
        model(s, a, b, eo, ez, ev);
        bus.sgn   = s;
        bus.in_1  = a;
        bus.in_2  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.sgn   = ~s;
        bus.in_1  = vec_t'({$urandom, $urandom});
        bus.in_2  = vec_t'({$urandom, $urandom});
        check({tag, "_done_clr"}, bus.done, 0);
        check({tag, "_busy0"}, bus.busy, 0);
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 200) begin
            bus.start = (lat == poke_at);
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_busycyc"}, bcnt, LAT - 1);
        check({tag, "_out"}, bus.out, eo);
        check({tag, "_dbz"}, bus.dbz, ez);
        check({tag, "_ovf"}, bus.ovf, ev);
    endtask

    task automatic check_exp(input string tag, input vec_t eo, input logic [LANES-1:0] ez,
                             input logic [LANES-1:0] ev);
        check({tag, "_kout"}, bus.out, eo);
        check({tag, "_kdbz"}, bus.dbz, ez);
        check({tag, "_kovf"}, bus.ovf, ev);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.in_1  = '0;
        bus.in_2  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", bus.out, 0);
        check("rst_flags", {bus.dbz, bus.ovf, bus.busy, bus.done}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plan vectors, lane 0 listed last in each literal; back-to-back ops start on the done cycle.
        do_op("basic", 1'b1, {16'h0040, 16'h0100, 16'h0A00, 16'h0F00},
              {16'h0010, 16'h0100, 16'h0200, 16'h0280}, -1);
        check_exp("basic", {16'h0400, 16'h0100, 16'h0500, 16'h0600}, 4'b0000, 4'b0000);
        do_op("sign", 1'b1, {16'h8000, 16'h6400, 16'hE980, 16'hE980},
              {16'h0100, 16'h0002, 16'h0380, 16'hFC80}, -1);
`ifdef VEC_DIV_ROUND_EN
        check_exp("sign", {16'h8000, 16'h7FFF, 16'hF992, 16'h066E}, 4'b0000, 4'b0100);
`else
        check_exp("sign", {16'h8000, 16'h7FFF, 16'hF993, 16'h066D}, 4'b0000, 4'b0100);
`endif
        do_op("dbz", 1'b1, {16'h0A00, 16'h0000, 16'hFB00, 16'h0500},
              {16'h0200, 16'h0000, 16'h0000, 16'h0000}, -1);
        check_exp("dbz", {16'h0500, 16'h0000, 16'h8000, 16'h7FFF}, 4'b0111, 4'b0000);
        do_op("ovf", 1'b1, {16'hFF00, 16'h0100, 16'h0000, 16'h8000},
              {16'h0100, 16'h0300, 16'h0300, 16'hFF00}, -1);
        check_exp("ovf", {16'hFF00, 16'h0055, 16'h0000, 16'h7FFF}, 4'b0000, 4'b0001);
        do_op("uns", 1'b0, {16'h0000, 16'hFF00, 16'hFF00, 16'hFF00},
              {16'h0000, 16'h0000, 16'h0080, 16'h0200}, -1);
        check_exp("uns", {16'h0000, 16'hFFFF, 16'hFFFF, 16'h7F80}, 4'b1100, 4'b0010);

        // A start pulse while busy must be dropped: one done, first operands' result.
        do_op("poke", 1'b1, {16'h0300, 16'h0700, 16'hF000, 16'h1000},
              {16'h0200, 16'hFE00, 16'h0300, 16'h0080}, 5);
        extra = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        check("poke_no_second_done", extra, 0);

        for (int k = 0; k < 12; k++) begin
            for (int l = 0; l < LANES; l++) begin
                ra[l] = 16'($urandom);
                if ($urandom_range(0, 7) == 0) ra[l] = '0;
                case ($urandom_range(0, 3))
                    0:       rb[l] = 16'($urandom_range(0, 2));
                    1:       rb[l] = 16'($urandom_range(0, 255));
                    default: rb[l] = 16'($urandom);
                endcase
            end
            rs = 1'($urandom_range(0, 1));
            do_op($sformatf("rnd%0d", k), rs, ra, rb, -1);
        end

        // Reset ten edges into an operation: outputs clear at once, no done follows.
        bus.sgn   = 1'b1;
        bus.in_1  = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
        bus.in_2  = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out", bus.out, 0);
        check("midrst_flags", {bus.dbz, bus.ovf, bus.busy, bus.done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        extra = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        check("midrst_no_done", extra, 0);

        do_op("after_rst", 1'b1, {16'h0100, 16'hFD00, 16'h0300, 16'h0C00},
              {16'h0400, 16'h0100, 16'h0000, 16'h0300}, -1);
        check_exp("after_rst", {16'h0040, 16'hFD00, 16'h7FFF, 16'h0400}, 4'b0010, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
